// File: rtl/tour_move_seq_pkg.sv
// Shared definitions for the knight-tour move sequencer: FSM state encoding,
// command opcodes, heading codes and response bytes.
package tour_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VERT   = 3'd1,
      ST_HOLD_V = 3'd2,
      ST_HORZ   = 3'd3,
      ST_HOLD_H = 3'd4
   } tour_state_t;

   localparam logic [3:0] MOVE     = 4'h2;
   localparam logic [3:0] MOVE_FAN = 4'h3;

   localparam logic [7:0] HEAD_N = 8'h00;
   localparam logic [7:0] HEAD_W = 8'h3F;
   localparam logic [7:0] HEAD_S = 8'h7F;
   localparam logic [7:0] HEAD_E = 8'hBF;

   localparam logic [7:0] RESP_ACK  = 8'hA5;
   localparam logic [7:0] RESP_DONE = 8'h5A;

endpackage

// File: rtl/tour_move_seq_if.sv
// Signal bundle around the tour sequencer.
//   start_tour, move             : from cmd_proc / tour memory
//   mv_indx                      : index into the tour memory
//   cmd_UART, cmd_rdy_UART       : command from the UART wrapper
//   clr_cmd_rdy_UART             : consume strobe back to the UART wrapper
//   cmd, cmd_rdy                 : command to cmd_proc
//   clr_cmd_rdy, send_resp       : acceptance / segment-done from cmd_proc
//   resp                         : response byte to the UART
// master = sequencer side, slave = surrounding system.
interface tour_move_seq_if;
   logic        start_tour;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART;
   logic        cmd_rdy_UART;
   logic        clr_cmd_rdy_UART;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [7:0]  resp;

   modport master (
      input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
      output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
   );

   modport slave (
      output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
      input  mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
   );
endinterface

// File: rtl/tour_move_seq_decode.sv
// knight_move_decode: turns a one-hot knight move into a vertical segment
// (heading + squares) and a horizontal segment. Purely combinational.
//   move  in  8 : one-hot move
//   vhead out 8 / vsq out 4 : vertical heading and square count
//   hhead out 8 / hsq out 4 : horizontal heading and square count
//   valid out 1 : exactly one bit of move is set
module knight_move_decode
   import tour_pkg::*;
(
   input  logic [7:0] move,
   output logic [7:0] vhead,
   output logic [3:0] vsq,
   output logic [7:0] hhead,
   output logic [3:0] hsq,
   output logic       valid
);

   assign valid = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);

   always_comb begin
      vhead = HEAD_N;
      vsq   = 4'd0;
      hhead = HEAD_E;
      hsq   = 4'd0;
      case (move)
         8'h01: begin vhead = HEAD_N; vsq = 4'd2; hhead = HEAD_E; hsq = 4'd1; end
         8'h02: begin vhead = HEAD_N; vsq = 4'd2; hhead = HEAD_W; hsq = 4'd1; end
         8'h04: begin vhead = HEAD_N; vsq = 4'd1; hhead = HEAD_W; hsq = 4'd2; end
         8'h08: begin vhead = HEAD_S; vsq = 4'd1; hhead = HEAD_W; hsq = 4'd2; end
         8'h10: begin vhead = HEAD_S; vsq = 4'd2; hhead = HEAD_W; hsq = 4'd1; end
         8'h20: begin vhead = HEAD_S; vsq = 4'd2; hhead = HEAD_E; hsq = 4'd1; end
         8'h40: begin vhead = HEAD_S; vsq = 4'd1; hhead = HEAD_E; hsq = 4'd2; end
         8'h80: begin vhead = HEAD_N; vsq = 4'd1; hhead = HEAD_E; hsq = 4'd2; end
         default: ;
      endcase
   end

endmodule

// File: rtl/tour_move_seq.sv
// tour_move_seq: arbitrates the cmd_proc command port between the UART path
// (idle) and the solved knight tour (touring). Each move is issued as a
// vertical segment then a horizontal segment; one response per segment.
//   clk, rst : clock, async active-high reset
//   bus      : tour_move_seq_if.master (see interface for signal list)
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | UART commands pass straight through to cmd_proc
// ST_VERT   | offering vertical segment of move[mv_indx]
// ST_HOLD_V | vertical segment accepted, waiting for send_resp
// ST_HORZ   | offering horizontal segment (with fanfare)
// ST_HOLD_H | horizontal segment accepted, waiting for send_resp
module tour_move_seq
   import tour_pkg::*;
#(
   parameter int NUM_MOVES = 24
) (
   input  logic          clk,
   input  logic          rst,
   tour_move_seq_if.master bus
);

   localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

   tour_state_t state_q, state_d;
   logic [4:0]  mv_indx_q, mv_indx_d;

   logic [7:0] vhead, hhead;
   logic [3:0] vsq, hsq;
   logic       move_valid;
   logic       last_move;

   knight_move_decode u_decode (
      .move  (bus.move),
      .vhead (vhead),
      .vsq   (vsq),
      .hhead (hhead),
      .hsq   (hsq),
      .valid (move_valid)
   );

   assign last_move   = (mv_indx_q == LAST_INDX);
   assign bus.mv_indx = mv_indx_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mv_indx_q <= 5'd0;
      end else begin
         state_q   <= state_d;
         mv_indx_q <= mv_indx_d;
      end
   end

   always_comb begin
      state_d              = state_q;
      mv_indx_d            = mv_indx_q;
      bus.cmd              = bus.cmd_UART;
      bus.cmd_rdy          = 1'b0;
      bus.clr_cmd_rdy_UART = 1'b0;
      bus.resp             = RESP_ACK;
      case (state_q)
         ST_IDLE: begin
            bus.cmd_rdy          = bus.cmd_rdy_UART;
            bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
            if (bus.start_tour) begin
               mv_indx_d = 5'd0;
               state_d   = ST_VERT;
            end
         end
         ST_VERT: begin
            bus.cmd     = {MOVE, vhead, vsq};
            bus.cmd_rdy = move_valid;
            // A corrupt tour entry aborts the tour rather than driving the
            // knight somewhere undefined.
            if (!move_valid)
               state_d = ST_IDLE;
            else if (bus.clr_cmd_rdy)
               state_d = ST_HOLD_V;
         end
         ST_HOLD_V: begin
            bus.cmd = {MOVE, vhead, vsq};
            if (bus.send_resp)
               state_d = ST_HORZ;
         end
         ST_HORZ: begin
            bus.cmd     = {MOVE_FAN, hhead, hsq};
            bus.cmd_rdy = 1'b1;
            if (bus.clr_cmd_rdy)
               state_d = ST_HOLD_H;
         end
         ST_HOLD_H: begin
            bus.cmd = {MOVE_FAN, hhead, hsq};
            if (last_move)
               bus.resp = RESP_DONE;
            if (bus.send_resp) begin
               if (last_move) begin
                  state_d = ST_IDLE;
               end else begin
                  mv_indx_d = mv_indx_q + 5'd1;
                  state_d   = ST_VERT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_tour_move_seq.sv
module tb_tour_move_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tour_move_seq_if bus ();

   tour_move_seq #(.NUM_MOVES(24)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Tour memory model: move is combinational from mv_indx when use_mem is set.
   logic [7:0] tour_mem [32];
   logic [7:0] move_drv;
   logic       use_mem;
   always_comb bus.move = use_mem ? tour_mem[bus.mv_indx] : move_drv;

   int n_total  = 0;
   int n_passed = 0;
   int n_resp   = 0;

   logic [15:0] exp_cmd_q  [$];
   logic [7:0]  exp_resp_q [$];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] model_cmd(input logic [7:0] m, input bit horz);
      int dx, dy, a;
      dx = 0;
      dy = 0;
      case (m)
         8'h01: begin dx =  1; dy =  2; end
         8'h02: begin dx = -1; dy =  2; end
         8'h04: begin dx = -2; dy =  1; end
         8'h08: begin dx = -2; dy = -1; end
         8'h10: begin dx = -1; dy = -2; end
         8'h20: begin dx =  1; dy = -2; end
         8'h40: begin dx =  2; dy = -1; end
         8'h80: begin dx =  2; dy =  1; end
         default: ;
      endcase
      if (horz) begin
         a = (dx < 0) ? -dx : dx;
         return {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'(a)};
      end
      a = (dy < 0) ? -dy : dy;
      return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'(a)};
   endfunction

   task automatic push_move(input logic [7:0] m, input bit last);
      exp_cmd_q.push_back(model_cmd(m, 1'b0));
      exp_cmd_q.push_back(model_cmd(m, 1'b1));
      exp_resp_q.push_back(8'hA5);
      exp_resp_q.push_back(last ? 8'h5A : 8'hA5);
   endtask

   task automatic chk_cmd_sb(input string tag);
      logic [15:0] e;
      e = (exp_cmd_q.size() > 0) ? exp_cmd_q.pop_front() : 16'hxxxx;
      chk(tag, bus.cmd, e);
   endtask

   task automatic chk_resp_sb(input string tag);
      logic [7:0] e;
      e = (exp_resp_q.size() > 0) ? exp_resp_q.pop_front() : 8'hxx;
      chk(tag, 16'(bus.resp), 16'(e));
      n_resp++;
   endtask

   task automatic wait_rdy(input string tag);
      int n;
      n = 0;
      while (bus.cmd_rdy !== 1'b1 && n < 20) begin
         tick();
         #1;
         n++;
      end
      chk(tag, 16'(bus.cmd_rdy), 16'd1);
   endtask

   task automatic start_pulse();
      bus.start_tour = 1'b1;
      tick();
      bus.start_tour = 1'b0;
      #1;
   endtask

   task automatic idle_probe(input string tag);
      bus.clr_cmd_rdy = 1'b1;
      #1;
      chk(tag, 16'(bus.clr_cmd_rdy_UART), 16'd1);
      bus.clr_cmd_rdy = 1'b0;
      #1;
   endtask

   // One move: vertical handshake, stray events in HOLD_V, horizontal handshake.
   task automatic do_move(input int idx);
      wait_rdy("vert_rdy");
      chk_cmd_sb("vert_cmd");
      chk("vert_indx", 16'(bus.mv_indx), 16'(idx));
      bus.clr_cmd_rdy = 1'b1;
      #1;
      chk("uart_clr_blocked", 16'(bus.clr_cmd_rdy_UART), 16'd0);
      tick();
      bus.clr_cmd_rdy = 1'b0;
      #1;
      chk("hold_v_rdy", 16'(bus.cmd_rdy), 16'd0);
      bus.start_tour  = 1'b1;
      bus.clr_cmd_rdy = 1'b1;
      tick();
      bus.start_tour  = 1'b0;
      bus.clr_cmd_rdy = 1'b0;
      #1;
      chk("hold_v_ignore_rdy", 16'(bus.cmd_rdy), 16'd0);
      chk("hold_v_ignore_indx", 16'(bus.mv_indx), 16'(idx));
      bus.send_resp = 1'b1;
      #1;
      chk_resp_sb("vert_resp");
      tick();
      bus.send_resp = 1'b0;
      #1;
      wait_rdy("horz_rdy");
      chk_cmd_sb("horz_cmd");
      bus.clr_cmd_rdy = 1'b1;
      tick();
      bus.clr_cmd_rdy = 1'b0;
      #1;
      chk("hold_h_rdy", 16'(bus.cmd_rdy), 16'd0);
      bus.send_resp = 1'b1;
      #1;
      chk_resp_sb("horz_resp");
      tick();
      bus.send_resp = 1'b0;
      #1;
   endtask

   initial begin
      logic [7:0] bad_moves [2];
      bad_moves[0] = 8'h00;
      bad_moves[1] = 8'h03;

      rst              = 1'b1;
      use_mem          = 1'b0;
      move_drv         = 8'h00;
      bus.start_tour   = 1'b0;
      bus.cmd_UART     = 16'h1234;
      bus.cmd_rdy_UART = 1'b0;
      bus.clr_cmd_rdy  = 1'b0;
      bus.send_resp    = 1'b0;
      for (int i = 0; i < 32; i++) tour_mem[i] = 8'(1 << $urandom_range(0, 7));

      repeat (2) tick();
      #1;
      chk("rst_cmd_rdy", 16'(bus.cmd_rdy), 16'd0);
      chk("rst_clr_uart", 16'(bus.clr_cmd_rdy_UART), 16'd0);
      chk("rst_cmd", bus.cmd, 16'h1234);
      chk("rst_resp", 16'(bus.resp), 16'h00A5);
      chk("rst_indx", 16'(bus.mv_indx), 16'd0);
      rst = 1'b0;
      tick();

      // Idle pass-through
      bus.cmd_UART     = 16'h2002;
      bus.cmd_rdy_UART = 1'b1;
      bus.clr_cmd_rdy  = 1'b1;
      #1;
      chk("pt_cmd", bus.cmd, 16'h2002);
      chk("pt_cmd_rdy", 16'(bus.cmd_rdy), 16'd1);
      chk("pt_clr_uart", 16'(bus.clr_cmd_rdy_UART), 16'd1);
      chk("pt_resp", 16'(bus.resp), 16'h00A5);
      bus.clr_cmd_rdy  = 1'b0;
      bus.cmd_rdy_UART = 1'b0;
      tick();

      // Decode sweep: one move per tour, then an invalid entry aborts it.
      for (int b = 0; b < 8; b++) begin
         move_drv = 8'(1 << b);
         push_move(move_drv, 1'b0);
         start_pulse();
         chk("start_cmd_rdy", 16'(bus.cmd_rdy), 16'd1);
         do_move(0);
         move_drv = 8'h00;
         #1;
         chk("abort_cmd_rdy", 16'(bus.cmd_rdy), 16'd0);
         tick();
         idle_probe("abort_idle");
      end

      // Invalid moves right at tour start
      for (int k = 0; k < 2; k++) begin
         move_drv = bad_moves[k];
         start_pulse();
         chk("bad_cmd_rdy", 16'(bus.cmd_rdy), 16'd0);
         tick();
         #1;
         chk("bad_idle_rdy", 16'(bus.cmd_rdy), 16'd0);
         idle_probe("bad_idle");
      end

      // Full tour from memory with a UART command pending throughout.
      use_mem          = 1'b1;
      bus.cmd_UART     = 16'h4321;
      bus.cmd_rdy_UART = 1'b1;
      n_resp           = 0;
      for (int i = 0; i < 24; i++) push_move(tour_mem[i], i == 23);
      start_pulse();
      chk("tour_start_indx", 16'(bus.mv_indx), 16'd0);
      for (int i = 0; i < 24; i++) do_move(i);
      chk("tour_resp_count", 16'(n_resp), 16'd48);
      chk("tour_sb_cmd_empty", 16'(exp_cmd_q.size()), 16'd0);
      chk("tour_sb_resp_empty", 16'(exp_resp_q.size()), 16'd0);
      chk("tour_end_cmd", bus.cmd, 16'h4321);
      chk("tour_end_cmd_rdy", 16'(bus.cmd_rdy), 16'd1);
      idle_probe("tour_end_idle");
      bus.cmd_rdy_UART = 1'b0;
      tick();

      // Reset in HOLD_V of the third move
      push_move(tour_mem[0], 1'b0);
      push_move(tour_mem[1], 1'b0);
      start_pulse();
      do_move(0);
      do_move(1);
      exp_cmd_q.push_back(model_cmd(tour_mem[2], 1'b0));
      wait_rdy("rst_vert_rdy");
      chk_cmd_sb("rst_vert_cmd");
      bus.clr_cmd_rdy = 1'b1;
      tick();
      bus.clr_cmd_rdy = 1'b0;
      #1;
      chk("pre_rst_indx", 16'(bus.mv_indx), 16'd2);
      rst = 1'b1;
      #1;
      chk("mid_rst_indx", 16'(bus.mv_indx), 16'd0);
      chk("mid_rst_cmd_rdy", 16'(bus.cmd_rdy), 16'd0);
      tick();
      rst = 1'b0;
      tick();
      idle_probe("post_rst_idle");
      repeat (3) tick();
      chk("post_rst_no_resume", 16'(bus.cmd_rdy), 16'd0);
      chk("post_rst_indx", 16'(bus.mv_indx), 16'd0);
      exp_cmd_q.delete();
      exp_resp_q.delete();

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
